// File: rtl/fetch_pc_unit.sv
// fetch_pc_unit: RV32I instruction-fetch front end.
// Holds the fetch PC, issues in-order requests to instruction memory under a
// credit limit, pairs each response with its request PC and buffers the
// resulting {pc, word} pairs toward decode. A taken branch from EX redirects
// the PC, clears the buffer and drops in-flight wrong-path responses.
//
// Optional build macro: FETCH_MISALIGN_EN
//   defined   : a misaligned redirect target sends the PC to TRAP_VEC and
//               pulses o_misalign_1 the following cycle.
//   undefined : the target is forced word aligned, o_misalign_1 is tied 0.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_BOOT  | first cycle after reset, no request issued
// S_RUN   | normal fetching
// S_DRAIN | wrong-path responses still in flight, dropped on arrival
module fetch_pc_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          MAX_CREDIT = 2
`ifdef FETCH_MISALIGN_EN
  ,
  parameter logic [31:0] TRAP_VEC   = 32'h0000_0100
`endif
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_isBranch_1,
  input  logic [31:0] i_branchPC_32,
  input  logic        i_exValid_1,
  output logic        o_imemReq_1,
  output logic [31:0] o_imemAddr_32,
  input  logic        i_imemReady_1,
  input  logic        i_imemValid_1,
  input  logic [31:0] i_imemData_32,
  output logic        o_instValid_1,
  output logic [31:0] o_inst_32,
  output logic [31:0] o_instPC_32,
  input  logic        i_idReady_1,
  output logic        o_flush_1,
  output logic        o_misalign_1
);

  // CW holds 0..MAX_CREDIT, SW holds the sum of two such counts
  localparam int CW = $clog2(MAX_CREDIT + 1);
  localparam int SW = CW + 1;
  localparam int PW = (MAX_CREDIT > 1) ? $clog2(MAX_CREDIT) : 1;

  typedef enum logic [1:0] {
    S_BOOT  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [31:0]   pc_q;
  logic [CW-1:0] outstanding_q;
  logic [CW-1:0] drop_q;
  logic [CW-1:0] occ_q;

  // request-PC FIFO: one entry per outstanding request, dropped ones included
  logic [31:0]   reqpc_mem [MAX_CREDIT];
  logic [PW-1:0] reqpc_wr_q, reqpc_rd_q;

  // instruction buffer toward decode
  logic [31:0]   buf_pc_mem   [MAX_CREDIT];
  logic [31:0]   buf_data_mem [MAX_CREDIT];
  logic [PW-1:0] buf_wr_q, buf_rd_q;

  logic          redirect;
  logic [31:0]   redirect_pc;
  logic          credit_ok;
  logic          req;
  logic          req_fire;
  logic          rsp_accept;
  logic          rsp_drop;
  logic          rsp_keep;
  logic          pop;
  logic [CW-1:0] drop_redirect;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    if (p == PW'(MAX_CREDIT - 1)) return '0;
    return p + PW'(1);
  endfunction

  assign redirect = i_isBranch_1 & i_exValid_1;

`ifdef FETCH_MISALIGN_EN
  logic target_misaligned;
  logic misalign_q;

  assign target_misaligned = (i_branchPC_32[1:0] != 2'b00);
  assign redirect_pc       = target_misaligned ? TRAP_VEC : i_branchPC_32;

  // one-cycle pulse the cycle after a redirect to a misaligned target
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) misalign_q <= 1'b0;
    else          misalign_q <= redirect & target_misaligned;
  end

  assign o_misalign_1 = misalign_q;
`else
  assign redirect_pc  = i_branchPC_32 & 32'hFFFF_FFFC;
  assign o_misalign_1 = 1'b0;
`endif

  // outstanding already counts wrong-path requests, so draining also eats credit
  assign credit_ok  = (SW'(outstanding_q) + SW'(occ_q)) < SW'(MAX_CREDIT);
  assign req        = (state_q != S_BOOT) & ~redirect & credit_ok;
  assign req_fire   = req & i_imemReady_1;

  // a response with nothing outstanding is stray and ignored
  assign rsp_accept = i_imemValid_1 & (outstanding_q != '0);
  assign rsp_drop   = rsp_accept & (drop_q != '0);
  assign rsp_keep   = rsp_accept & (drop_q == '0) & ~redirect;
  assign pop        = o_instValid_1 & i_idReady_1;

  // the response arriving in the redirect cycle is discarded right here,
  // so only the ones still in flight afterwards need dropping
  assign drop_redirect = outstanding_q - CW'(rsp_accept);

  // state register
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) state_q <= S_BOOT;
    else          state_q <= state_d;
  end

  // next-state: boot lasts one cycle, drain ends with the last dropped word
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_BOOT:  state_d = S_RUN;
      S_RUN:   state_d = S_RUN;
      S_DRAIN: if (rsp_drop && (drop_q == CW'(1))) state_d = S_RUN;
      default: state_d = S_BOOT;
    endcase
    if (redirect) state_d = (drop_redirect != '0) ? S_DRAIN : S_RUN;
  end

  // fetch PC, outstanding count and drop count
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      pc_q          <= RESET_PC;
      outstanding_q <= '0;
      drop_q        <= '0;
    end else begin
      if (redirect)      pc_q <= redirect_pc;
      else if (req_fire) pc_q <= pc_q + 32'd4;
      outstanding_q <= outstanding_q + CW'(req_fire) - CW'(rsp_accept);
      if (redirect)      drop_q <= drop_redirect;
      else if (rsp_drop) drop_q <= drop_q - CW'(1);
    end
  end

  // request-PC FIFO pointers
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      reqpc_wr_q <= '0;
      reqpc_rd_q <= '0;
    end else begin
      if (req_fire)   reqpc_wr_q <= ptr_inc(reqpc_wr_q);
      if (rsp_accept) reqpc_rd_q <= ptr_inc(reqpc_rd_q);
    end
  end

  // request-PC FIFO storage
  always_ff @(posedge i_clk) begin
    if (req_fire) reqpc_mem[reqpc_wr_q] <= pc_q;
  end

  // instruction buffer pointers and occupancy; a redirect empties it
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      buf_wr_q <= '0;
      buf_rd_q <= '0;
      occ_q    <= '0;
    end else if (redirect) begin
      buf_wr_q <= '0;
      buf_rd_q <= '0;
      occ_q    <= '0;
    end else begin
      if (rsp_keep) buf_wr_q <= ptr_inc(buf_wr_q);
      if (pop)      buf_rd_q <= ptr_inc(buf_rd_q);
      occ_q <= occ_q + CW'(rsp_keep) - CW'(pop);
    end
  end

  // instruction buffer storage, each word paired with its request PC
  always_ff @(posedge i_clk) begin
    if (rsp_keep) begin
      buf_pc_mem[buf_wr_q]   <= reqpc_mem[reqpc_rd_q];
      buf_data_mem[buf_wr_q] <= i_imemData_32;
    end
  end

  assign o_imemReq_1   = req;
  assign o_imemAddr_32 = pc_q;
  assign o_flush_1     = redirect;
  assign o_instValid_1 = (occ_q != '0);
  assign o_inst_32     = o_instValid_1 ? buf_data_mem[buf_rd_q] : 32'h0;
  assign o_instPC_32   = o_instValid_1 ? buf_pc_mem[buf_rd_q]   : 32'h0;

`ifndef SYNTHESIS
  a_rsp_has_request: assert property (@(posedge i_clk) disable iff (!i_rst_n)
    i_imemValid_1 |-> (outstanding_q != '0));

  a_rsp_not_full: assert property (@(posedge i_clk) disable iff (!i_rst_n)
    i_imemValid_1 |-> (occ_q != CW'(MAX_CREDIT)));
`endif

endmodule

// File: tb/tb_fetch_pc_unit.sv
// tb_fetch_pc_unit: directed vector table for boot, decode stall, redirect,
// double redirect, PC wrap and misaligned target, then randomized traffic.
// A small program-order model checks every request address and every word
// decode accepts; a memory model returns words in order after 1..3 cycles.
module tb_fetch_pc_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        is_branch = 1'b0;
  logic [31:0] branch_pc = 32'h0;
  logic        ex_valid = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready = 1'b0;
  logic        imem_valid = 1'b0;
  logic [31:0] imem_data = 32'h0;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        id_ready = 1'b0;
  logic        flush;
  logic        misalign;

  always #5 clk = ~clk;

  fetch_pc_unit dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_isBranch_1  (is_branch),
    .i_branchPC_32 (branch_pc),
    .i_exValid_1   (ex_valid),
    .o_imemReq_1   (imem_req),
    .o_imemAddr_32 (imem_addr),
    .i_imemReady_1 (imem_ready),
    .i_imemValid_1 (imem_valid),
    .i_imemData_32 (imem_data),
    .o_instValid_1 (inst_valid),
    .o_inst_32     (inst),
    .o_instPC_32   (inst_pc),
    .i_idReady_1   (id_ready),
    .o_flush_1     (flush),
    .o_misalign_1  (misalign)
  );

`ifdef FETCH_MISALIGN_EN
  localparam logic [31:0] MIS_PC = 32'h0000_0100;
`else
  localparam logic [31:0] MIS_PC = 32'h0000_0200;
`endif

  int n_vec  = 0;
  int n_fail = 0;
  int cyc    = 0;
  int delivered = 0;
  int mis_pulses = 0;

  // memory model: in-order responses, each due some cycles after its request
  typedef struct { logic [31:0] addr; int due; } mreq_t;
  mreq_t mq[$];

  // program-order model
  logic [31:0] exp_fetch   = 32'h0;
  logic [31:0] exp_deliver = 32'h0;
  logic        mis_pending = 1'b0;
  logic        rst_prev    = 1'b0;

  typedef struct {
    logic        rst;
    logic        br;
    logic [31:0] bpc;
    logic        idr;
    int          lat;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_iv;
    logic [31:0] e_ipc;
    logic        e_fl;
  } vec_t;
  vec_t tbl[$];

  function automatic logic [31:0] word_at(input logic [31:0] a);
    return a ^ {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  function automatic logic [31:0] target_of(input logic [31:0] b);
`ifdef FETCH_MISALIGN_EN
    if (b[1:0] != 2'b00) return 32'h0000_0100;
    return b;
`else
    return {b[31:2], 2'b00};
`endif
  endfunction

  function automatic logic is_misaligned(input logic [31:0] b);
`ifdef FETCH_MISALIGN_EN
    return b[1:0] != 2'b00;
`else
    return 1'b0;
`endif
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
    end
  endtask

  task automatic add(input logic rst, input logic br, input logic [31:0] bpc, input logic idr,
                     input int lat, input logic e_req, input logic [31:0] e_addr,
                     input logic e_iv, input logic [31:0] e_ipc, input logic e_fl);
    vec_t v;
    v.rst = rst; v.br = br; v.bpc = bpc; v.idr = idr; v.lat = lat;
    v.e_req = e_req; v.e_addr = e_addr; v.e_iv = e_iv; v.e_ipc = e_ipc; v.e_fl = e_fl;
    tbl.push_back(v);
  endtask

  // One clock cycle: drive inputs after the edge, check at the falling edge.
  task automatic step(input logic rst, input logic br, input logic exv, input logic [31:0] bpc,
                      input logic rdy, input logic idr, input logic rsp_en, input int lat);
    logic redirect;
    mreq_t m;
    @(posedge clk);
    cyc++;
    #1;
    rst_n = rst; is_branch = br; ex_valid = exv; branch_pc = bpc;
    imem_ready = rdy; id_ready = idr;
    if (rst && rsp_en && (mq.size() > 0) && (mq[0].due <= cyc)) begin
      imem_valid = 1'b1;
      imem_data  = word_at(mq[0].addr);
    end else begin
      imem_valid = 1'b0;
      imem_data  = $urandom;
    end
    @(negedge clk);
    redirect = br & exv;
    if (!rst_prev) begin
      chk("reset_req", {31'h0, imem_req}, 32'h0);
      chk("reset_instvalid", {31'h0, inst_valid}, 32'h0);
      chk("reset_inst", inst, 32'h0);
      chk("reset_instpc", inst_pc, 32'h0);
      chk("reset_misalign", {31'h0, misalign}, 32'h0);
    end
    if (!rst) begin
      mq.delete();
      exp_fetch   = 32'h0;
      exp_deliver = 32'h0;
      mis_pending = 1'b0;
    end else begin
      chk("flush", {31'h0, flush}, {31'h0, redirect});
      if (redirect) chk("req_in_redirect", {31'h0, imem_req}, 32'h0);
      chk("misalign", {31'h0, misalign}, {31'h0, mis_pending});
      if (misalign) mis_pulses++;
      mis_pending = redirect & is_misaligned(bpc);
      if (imem_req) chk("fetch_addr", imem_addr, exp_fetch);
      if (imem_valid) void'(mq.pop_front());
      if (imem_req && rdy) begin
        m.addr = imem_addr;
        m.due  = cyc + lat;
        mq.push_back(m);
        exp_fetch = exp_fetch + 32'd4;
      end
      if (inst_valid && idr && !redirect) begin
        chk("deliver_pc", inst_pc, exp_deliver);
        chk("deliver_word", inst, word_at(exp_deliver));
        exp_deliver = exp_deliver + 32'd4;
        delivered++;
      end
      if (redirect) begin
        exp_fetch   = target_of(bpc);
        exp_deliver = target_of(bpc);
      end
    end
    rst_prev = rst;
  endtask

  initial begin
    // decode stalled from reset, then released
    add(1, 0, 0, 0, 1,  0, 32'h0,  0, 0,     0);
    add(1, 0, 0, 0, 1,  1, 32'h0,  0, 0,     0);
    add(1, 0, 0, 0, 1,  1, 32'h4,  0, 0,     0);
    for (int i = 0; i < 10; i++) add(1, 0, 0, 0, 1,  0, 32'h8, 1, 32'h0, 0);
    add(1, 0, 0, 1, 1,  0, 32'h8,  1, 32'h0, 0);
    add(1, 0, 0, 1, 1,  1, 32'h8,  1, 32'h4, 0);
    add(1, 0, 0, 1, 1,  1, 32'hC,  0, 0,     0);
    add(1, 0, 0, 1, 1,  0, 32'h10, 1, 32'h8, 0);
    add(1, 0, 0, 1, 1,  1, 32'h10, 1, 32'hC, 0);
    // reset mid-operation
    add(0, 0, 0, 1, 1,  1, 32'h14, 0, 0,     0);
    add(0, 0, 0, 1, 1,  0, 32'h0,  0, 0,     0);
    // 2-cycle memory: redirect with 2 outstanding and a response that cycle
    add(1, 0, 0,      1, 2,  0, 32'h0,   0, 0,       0);
    add(1, 0, 0,      1, 2,  1, 32'h0,   0, 0,       0);
    add(1, 0, 0,      1, 2,  1, 32'h4,   0, 0,       0);
    add(1, 1, 32'h200, 1, 2, 0, 32'h8,   0, 0,       1);
    add(1, 0, 0,      1, 2,  1, 32'h200, 0, 0,       0);
    add(1, 0, 0,      1, 2,  1, 32'h204, 0, 0,       0);
    add(1, 0, 0,      1, 2,  0, 32'h208, 0, 0,       0);
    add(1, 0, 0,      1, 2,  0, 32'h208, 1, 32'h200, 0);
    add(1, 0, 0,      1, 2,  1, 32'h208, 1, 32'h204, 0);
    // two redirects two cycles apart
    add(1, 1, 32'h300, 1, 2, 0, 32'h20C, 0, 0,       1);
    add(1, 0, 0,      1, 2,  1, 32'h300, 0, 0,       0);
    add(1, 1, 32'h400, 1, 2, 0, 32'h304, 0, 0,       1);
    add(1, 0, 0,      1, 2,  1, 32'h400, 0, 0,       0);
    add(1, 0, 0,      1, 2,  1, 32'h404, 0, 0,       0);
    add(1, 0, 0,      1, 2,  0, 32'h408, 0, 0,       0);
    add(1, 0, 0,      1, 2,  0, 32'h408, 1, 32'h400, 0);
    // redirect to the last word of the address space, PC wraps to 0
    add(1, 1, 32'hFFFF_FFFC, 1, 1, 0, 32'h408, 1, 32'h404, 1);
    add(1, 0, 0, 1, 1,  1, 32'hFFFF_FFFC, 0, 0,            0);
    add(1, 0, 0, 1, 1,  1, 32'h0,         0, 0,            0);
    add(1, 0, 0, 1, 1,  0, 32'h4,         1, 32'hFFFF_FFFC, 0);
    add(1, 0, 0, 1, 1,  1, 32'h4,         1, 32'h0,        0);
    // misaligned redirect target
    add(1, 1, 32'h202, 1, 1, 0, 32'h8,           0, 0,               1);
    add(1, 0, 0,      1, 1,  1, MIS_PC,          0, 0,               0);
    add(1, 0, 0,      1, 1,  1, MIS_PC + 32'h4,  0, 0,               0);
    add(1, 0, 0,      1, 1,  0, MIS_PC + 32'h8,  1, MIS_PC,          0);
    add(1, 0, 0,      1, 1,  1, MIS_PC + 32'h8,  1, MIS_PC + 32'h4,  0);

    step(0, 0, 0, 0, 1, 1, 1, 1);
    step(0, 0, 0, 0, 1, 1, 1, 1);
    foreach (tbl[i]) begin
      step(tbl[i].rst, tbl[i].br, tbl[i].br, tbl[i].bpc, 1'b1, tbl[i].idr, 1'b1, tbl[i].lat);
      chk($sformatf("tbl%0d_req", i), {31'h0, imem_req}, {31'h0, tbl[i].e_req});
      chk($sformatf("tbl%0d_addr", i), imem_addr, tbl[i].e_addr);
      chk($sformatf("tbl%0d_instvalid", i), {31'h0, inst_valid}, {31'h0, tbl[i].e_iv});
      if (tbl[i].e_iv) chk($sformatf("tbl%0d_instpc", i), inst_pc, tbl[i].e_ipc);
      chk($sformatf("tbl%0d_flush", i), {31'h0, flush}, {31'h0, tbl[i].e_fl});
    end
`ifdef FETCH_MISALIGN_EN
    chk("misalign_pulse_count", mis_pulses, 1);
`else
    chk("misalign_pulse_count", mis_pulses, 0);
`endif

    // branch flag without a valid EX instruction must not redirect
    step(1, 1, 0, 32'h500, 1, 1, 1, 1);
    chk("branch_no_exvalid_flush", {31'h0, flush}, 32'h0);
    chk("branch_no_exvalid_addr", imem_addr, MIS_PC + 32'hC);
    step(1, 0, 0, 0, 1, 1, 1, 1);
    chk("branch_no_exvalid_next", imem_addr, MIS_PC + 32'h10);

    // randomized traffic against the program-order model
    step(0, 0, 0, 0, 1, 1, 1, 1);
    step(0, 0, 0, 0, 1, 1, 1, 1);
    delivered = 0;
    for (int n = 0; n < 4000; n++) begin
      logic        r_rst, r_br, r_exv, r_rdy, r_idr, r_rsp;
      logic [31:0] r_bpc, r;
      int          sel;
      r_rst = ($urandom_range(0, 999) != 0);
      r_br  = r_rst && ($urandom_range(0, 99) < 6);
      r_exv = ($urandom_range(0, 3) != 0);
      r     = $urandom;
      sel   = $urandom_range(0, 9);
      if (sel == 0)      r_bpc = 32'hFFFF_FFF4;
      else if (sel == 1) r_bpc = {20'h0, r[11:0]};
      else               r_bpc = {20'h0, r[11:2], 2'b00};
      r_rdy = ($urandom_range(0, 3) != 0);
      r_idr = ($urandom_range(0, 9) < 7);
      r_rsp = ($urandom_range(0, 4) != 0);
      step(r_rst, r_br, r_exv, r_bpc, r_rdy, r_idr, r_rsp, $urandom_range(1, 3));
    end
    chk("random_liveness", {31'h0, (delivered > 200)}, 32'h1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
